// File: rtl/ram_arb_pkg.sv
// Shared types, constants and address-decode helpers for the RAM arbiter.
// The optional lock feature is enabled with RAM_ARB_LOCK_EN; LOCK_MAX is used only then.
package ram_arb_pkg;

   localparam int AW = 8;
   localparam int DW = 16;

   localparam logic [AW-1:0] RAM_WORDS = AW'(8);
   localparam logic [AW-1:0] IO_IN_AD  = AW'(65);
   localparam logic [2:0]    LOCK_MAX  = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      CAPTURE
   } state_t;

   // Reads may target any RAM word or the read-only IO input word.
   function automatic logic ad_readable(input logic [AW-1:0] ad);
      return (ad < RAM_WORDS) || (ad == IO_IN_AD);
   endfunction

   // Only the RAM words themselves accept writes.
   function automatic logic ad_writable(input logic [AW-1:0] ad);
      return (ad < RAM_WORDS);
   endfunction

endpackage

// File: rtl/ram_arb_if.sv
// Request/acknowledge bundle for the two RAM requesters (A = CPU, B = host).
// With RAM_ARB_LOCK_EN defined, each requester also carries a LOCK qualifier.
interface ram_arb_if;
   import ram_arb_pkg::*;

   logic          A_REQ;
   logic          A_WE;
   logic [AW-1:0] A_AD;
   logic [DW-1:0] A_WD;
   logic          A_ACK;
   logic          A_ERR;
   logic [DW-1:0] A_RD;

   logic          B_REQ;
   logic          B_WE;
   logic [AW-1:0] B_AD;
   logic [DW-1:0] B_WD;
   logic          B_ACK;
   logic          B_ERR;
   logic [DW-1:0] B_RD;

`ifdef RAM_ARB_LOCK_EN
   logic          A_LOCK;
   logic          B_LOCK;
`endif

   modport master (
`ifdef RAM_ARB_LOCK_EN
      output A_LOCK, B_LOCK,
`endif
      output A_REQ, A_WE, A_AD, A_WD,
      output B_REQ, B_WE, B_AD, B_WD,
      input  A_ACK, A_ERR, A_RD,
      input  B_ACK, B_ERR, B_RD
   );

   modport slave (
`ifdef RAM_ARB_LOCK_EN
      input  A_LOCK, B_LOCK,
`endif
      input  A_REQ, A_WE, A_AD, A_WD,
      input  B_REQ, B_WE, B_AD, B_WD,
      output A_ACK, A_ERR, A_RD,
      output B_ACK, B_ERR, B_RD
   );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker. A reserve qualifier pins the decision to one
// requester (used by the lock feature); otherwise a tie goes to the port
// that did not own the last grant.
module ram_arb_rr (
   input  logic eligA_i,
   input  logic eligB_i,
   input  logic lastB_i,
   input  logic reserveA_i,
   input  logic reserveB_i,
   output logic valid_o,
   output logic idB_o
);

   // Pick a winner: reservation first, then single eligible, then alternate on a tie.
   always_comb begin
      valid_o = 1'b0;
      idB_o   = lastB_i;
      if (reserveA_i) begin
         valid_o = eligA_i;
         idB_o   = 1'b0;
      end else if (reserveB_i) begin
         valid_o = eligB_i;
         idB_o   = 1'b1;
      end else if (eligA_i && eligB_i) begin
         valid_o = 1'b1;
         idB_o   = ~lastB_i;
      end else if (eligA_i) begin
         valid_o = 1'b1;
         idB_o   = 1'b0;
      end else if (eligB_i) begin
         valid_o = 1'b1;
         idB_o   = 1'b1;
      end
   end

endmodule

// File: rtl/ram_arb.sv
// Arbiter and access sequencer for the CPU data RAM. Serves one request at a
// time through IDLE -> ACCESS -> CAPTURE, allowing one clock of decoder latency.
// Define RAM_ARB_LOCK_EN to let a requester hold LOCK and chain up to LOCK_MAX
// back-to-back grants (atomic read-modify-write).
module ram_arb
   import ram_arb_pkg::*;
(
   input  logic          CLK,
   input  logic          RESET,
   ram_arb_if.slave      bus,
   output logic [AW-1:0] RAM_AD,
   output logic          RAM_WE,
   output logic [DW-1:0] RAM_WD,
   input  logic [DW-1:0] RAM_RD,
   output logic          BUSY,
   output logic          GNT_B
);

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [AW-1:0] ad_q, ad_d;
   logic [DW-1:0] wd_q, wd_d;
   logic          gntB_q, gntB_d;

   logic          aAck_q, aAck_d, aErr_q, aErr_d;
   logic          bAck_q, bAck_d, bErr_q, bErr_d;
   logic [DW-1:0] aRd_q, aRd_d, bRd_q, bRd_d;

   logic          eligA, eligB;
   logic          reserveA, reserveB;
   logic          gntValid, gntId;
   logic          capErr;
   logic [DW-1:0] capRd;

   // A requester whose ACK is high this cycle is not eligible, so a held REQ
   // does not start a second access during its own acknowledge.
   assign eligA = bus.A_REQ && !aAck_q;
   assign eligB = bus.B_REQ && !bAck_q;

   ram_arb_rr picker (
      .eligA_i    (eligA),
      .eligB_i    (eligB),
      .lastB_i    (gntB_q),
      .reserveA_i (reserveA),
      .reserveB_i (reserveB),
      .valid_o    (gntValid),
      .idB_o      (gntId)
   );

`ifdef RAM_ARB_LOCK_EN
   logic       lockPendA_q, lockPendA_d;
   logic       lockPendB_q, lockPendB_d;
   logic [2:0] streak_q, streak_d;
   logic       armA, armB;

   // In the ACK cycle of a locked requester the other port is held off; in
   // the following cycle the locked port is re-granted if it still requests.
   always_comb begin
      armA        = aAck_q && bus.A_LOCK && (streak_q < LOCK_MAX);
      armB        = bAck_q && bus.B_LOCK && (streak_q < LOCK_MAX);
      reserveA    = armA || (lockPendA_q && bus.A_REQ);
      reserveB    = armB || (lockPendB_q && bus.B_REQ);
      lockPendA_d = armA;
      lockPendB_d = armB;
      streak_d    = streak_q;
      if ((state_q == IDLE) && gntValid) begin
         streak_d = (reserveA || reserveB) ? streak_q + 3'd1 : 3'd1;
      end
   end

   // Lock bookkeeping: pending re-grant flags and length of the current chain.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         lockPendA_q <= 1'b0;
         lockPendB_q <= 1'b0;
         streak_q    <= 3'd0;
      end else begin
         lockPendA_q <= lockPendA_d;
         lockPendB_q <= lockPendB_d;
         streak_q    <= streak_d;
      end
   end
`else
   assign reserveA = 1'b0;
   assign reserveB = 1'b0;
`endif

   // Result of the access being completed: reads return decoder data only for
   // a readable address; writes always return zero data.
   assign capErr = we_q ? !ad_writable(ad_q) : !ad_readable(ad_q);
   assign capRd  = (!we_q && ad_readable(ad_q)) ? RAM_RD : '0;

   // Next-state logic: latch the granted request, drive one RAM cycle, then
   // capture the decoder output and acknowledge the owner.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      ad_d    = ad_q;
      wd_d    = wd_q;
      gntB_d  = gntB_q;
      aAck_d  = 1'b0;
      bAck_d  = 1'b0;
      aErr_d  = 1'b0;
      bErr_d  = 1'b0;
      aRd_d   = aRd_q;
      bRd_d   = bRd_q;
      case (state_q)
         IDLE: begin
            if (gntValid) begin
               state_d = ACCESS;
               gntB_d  = gntId;
               if (gntId) begin
                  we_d = bus.B_WE;
                  ad_d = bus.B_AD;
                  wd_d = bus.B_WD;
               end else begin
                  we_d = bus.A_WE;
                  ad_d = bus.A_AD;
                  wd_d = bus.A_WD;
               end
            end
         end
         ACCESS: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            state_d = IDLE;
            if (gntB_q) begin
               bAck_d = 1'b1;
               bErr_d = capErr;
               bRd_d  = capRd;
            end else begin
               aAck_d = 1'b1;
               aErr_d = capErr;
               aRd_d  = capRd;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and response registers; GNT_B resets to B so that A wins the first tie.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         ad_q    <= '0;
         wd_q    <= '0;
         gntB_q  <= 1'b1;
         aAck_q  <= 1'b0;
         bAck_q  <= 1'b0;
         aErr_q  <= 1'b0;
         bErr_q  <= 1'b0;
         aRd_q   <= '0;
         bRd_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         ad_q    <= ad_d;
         wd_q    <= wd_d;
         gntB_q  <= gntB_d;
         aAck_q  <= aAck_d;
         bAck_q  <= bAck_d;
         aErr_q  <= aErr_d;
         bErr_q  <= bErr_d;
         aRd_q   <= aRd_d;
         bRd_q   <= bRd_d;
      end
   end

   assign RAM_AD = ad_q;
   assign RAM_WD = wd_q;
   assign RAM_WE = (state_q == ACCESS) && we_q && ad_writable(ad_q);
   assign BUSY   = (state_q != IDLE);
   assign GNT_B  = gntB_q;

   assign bus.A_ACK = aAck_q;
   assign bus.A_ERR = aErr_q;
   assign bus.A_RD  = aRd_q;
   assign bus.B_ACK = bAck_q;
   assign bus.B_ERR = bErr_q;
   assign bus.B_RD  = bRd_q;

endmodule

// File: tb/tb_ram_arb.sv
// Directed testbench for ram_arb: a small RAM/decoder model with one clock of
// read latency, directed accesses and immediate assertions on the results.
// The lock scenario runs only when RAM_ARB_LOCK_EN is defined.
module tb_ram_arb;
   import ram_arb_pkg::*;

   logic          CLK = 1'b0;
   logic          RESET;
   logic [AW-1:0] RAM_AD;
   logic          RAM_WE;
   logic [DW-1:0] RAM_WD;
   logic [DW-1:0] RAM_RD = '0;
   logic          BUSY;
   logic          GNT_B;

   logic [15:0] mem [8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                            16'hA004, 16'hA005, 16'hA006, 16'hA007};
   logic [15:0] io65;
   int          weTotal = 0;
   logic [7:0]  lastWeAd = '0;

   int checkCount = 0;
   int passCount  = 0;

   ram_arb_if bus ();

   ram_arb dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .bus    (bus),
      .RAM_AD (RAM_AD),
      .RAM_WE (RAM_WE),
      .RAM_WD (RAM_WD),
      .RAM_RD (RAM_RD),
      .BUSY   (BUSY),
      .GNT_B  (GNT_B)
   );

   always #5 CLK = ~CLK;

   // RAM file plus registered read decoder, and a count of write strobes
   always @(posedge CLK) begin
      if (RAM_WE) begin
         if (RAM_AD < 8'd8) mem[RAM_AD[2:0]] <= RAM_WD;
         weTotal  <= weTotal + 1;
         lastWeAd <= RAM_AD;
      end
      if (RAM_AD < 8'd8)       RAM_RD <= mem[RAM_AD[2:0]];
      else if (RAM_AD == 8'd65) RAM_RD <= io65;
      else                      RAM_RD <= 16'h0000;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // One request from port A (isB=0) or B; address/data are scrambled after
   // the grant edge to show they were latched. Latency counts clock edges from
   // the sampling edge up to the negedge where ACK is seen (3 = ACK after edge k+2).
   task automatic applyStimulus(input logic isB, input logic we, input logic [7:0] ad,
                                input logic [15:0] wd, output int lat, output logic err,
                                output logic [15:0] rd, output int weDelta);
      int   weStart;
      logic got;
      @(negedge CLK);
      weStart = weTotal;
      if (isB) begin
         bus.B_REQ = 1'b1; bus.B_WE = we; bus.B_AD = ad; bus.B_WD = wd;
      end else begin
         bus.A_REQ = 1'b1; bus.A_WE = we; bus.A_AD = ad; bus.A_WD = wd;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge CLK);
         lat++;
         @(negedge CLK);
         if (lat == 1) begin
            bus.A_AD = ~ad; bus.A_WD = ~wd; bus.B_AD = ~ad; bus.B_WD = ~wd;
         end
         got = isB ? bus.B_ACK : bus.A_ACK;
      end
      err = isB ? bus.B_ERR : bus.A_ERR;
      rd  = isB ? bus.B_RD : bus.A_RD;
      bus.A_REQ = 1'b0;
      bus.B_REQ = 1'b0;
      weDelta = weTotal - weStart;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int          lat, weDelta, cyc, ackCount, dualAck, aAckSeen;
      logic        err;
      logic [15:0] rd, firstARd, firstBRd;
      logic [4:0]  ackSeq;

      RESET = 1'b1;
      io65  = 16'hBEEF;
      bus.A_REQ = 0; bus.A_WE = 0; bus.A_AD = '0; bus.A_WD = '0;
      bus.B_REQ = 0; bus.B_WE = 0; bus.B_AD = '0; bus.B_WD = '0;
`ifdef RAM_ARB_LOCK_EN
      bus.A_LOCK = 0; bus.B_LOCK = 0;
`endif

      // Reset values
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst_ack", {bus.A_ACK, bus.B_ACK, bus.A_ERR, bus.B_ERR}, 0);
      checkOutput("rst_rd", {bus.A_RD, bus.B_RD}, 0);
      checkOutput("rst_ram", {RAM_AD, RAM_WE, RAM_WD}, 0);
      checkOutput("rst_busy", BUSY, 0);
      checkOutput("rst_gntb", GNT_B, 1);
      RESET = 1'b0;
      $display("[TB] reset released");

      // Simultaneous requests held high: A first, then strict alternation
      @(negedge CLK);
      bus.A_REQ = 1; bus.A_WE = 0; bus.A_AD = 8'd0;
      bus.B_REQ = 1; bus.B_WE = 0; bus.B_AD = 8'd1;
      ackSeq = '0; ackCount = 0; dualAck = 0; cyc = 0;
      firstARd = '0; firstBRd = '0;
      while (ackCount < 4 && cyc < 60) begin
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
         if (bus.A_ACK && bus.B_ACK) dualAck++;
         if (bus.A_ACK || bus.B_ACK) begin
            ackSeq = {ackSeq[3:0], bus.B_ACK};
            if (ackCount == 0) firstARd = bus.A_RD;
            if (ackCount == 1) firstBRd = bus.B_RD;
            ackCount++;
            if (ackCount == 4) begin
               bus.A_REQ = 0; bus.B_REQ = 0;
            end
         end
      end
      checkOutput("rr_count", ackCount, 4);
      checkOutput("rr_order", ackSeq[3:0], 4'b0101);
      checkOutput("rr_dual", dualAck, 0);
      checkOutput("rr_cycles", cyc, 12);
      checkOutput("rr_a_rd", firstARd, 16'hA000);
      checkOutput("rr_b_rd", firstBRd, 16'hA001);

      // A writes 0x1234 to word 3, then reads it back
      applyStimulus(1'b0, 1'b1, 8'd3, 16'h1234, lat, err, rd, weDelta);
      checkOutput("wr3_lat", lat, 3);
      checkOutput("wr3_err", err, 0);
      checkOutput("wr3_rd", rd, 0);
      checkOutput("wr3_we", weDelta, 1);
      checkOutput("wr3_ad", lastWeAd, 3);
      @(negedge CLK);
      checkOutput("wr3_ack_width", bus.A_ACK, 0);
      applyStimulus(1'b0, 1'b0, 8'd3, 16'h0000, lat, err, rd, weDelta);
      checkOutput("rd3_lat", lat, 3);
      checkOutput("rd3_rd", rd, 16'h1234);
      checkOutput("rd3_err", err, 0);

      // B reads and then tries to write the IO input word
      applyStimulus(1'b1, 1'b0, 8'd65, 16'h0000, lat, err, rd, weDelta);
      checkOutput("rd65_rd", rd, 16'hBEEF);
      checkOutput("rd65_err", err, 0);
      applyStimulus(1'b1, 1'b1, 8'd65, 16'h7777, lat, err, rd, weDelta);
      checkOutput("wr65_err", err, 1);
      checkOutput("wr65_we", weDelta, 0);
      checkOutput("wr65_rd", rd, 0);

      // A accesses unmapped addresses
      applyStimulus(1'b0, 1'b0, 8'd9, 16'h0000, lat, err, rd, weDelta);
      checkOutput("rd9_lat", lat, 3);
      checkOutput("rd9_err", err, 1);
      checkOutput("rd9_rd", rd, 0);
      applyStimulus(1'b0, 1'b1, 8'd200, 16'h5A5A, lat, err, rd, weDelta);
      checkOutput("wr200_err", err, 1);
      checkOutput("wr200_we", weDelta, 0);
      checkOutput("wr200_lat", lat, 3);

      // Reset during the ACCESS cycle of a write aborts it
      @(negedge CLK);
      bus.A_REQ = 1; bus.A_WE = 1; bus.A_AD = 8'd5; bus.A_WD = 16'h5555;
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("abort_we_access", RAM_WE, 1);
      RESET = 1'b1;
      bus.A_REQ = 0;
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      checkOutput("abort_busy", BUSY, 0);
      checkOutput("abort_gntb", GNT_B, 1);
      checkOutput("abort_we", RAM_WE, 0);
      aAckSeen = 0;
      repeat (5) begin
         @(negedge CLK);
         if (bus.A_ACK) aAckSeen++;
      end
      checkOutput("abort_no_ack", aAckSeen, 0);
      applyStimulus(1'b0, 1'b0, 8'd3, 16'h0000, lat, err, rd, weDelta);
      checkOutput("post_rst_lat", lat, 3);
      checkOutput("post_rst_rd", rd, 16'h1234);

`ifdef RAM_ARB_LOCK_EN
      // A holds LOCK: four back-to-back grants to A, then B
      @(negedge CLK);
      bus.A_REQ = 1; bus.A_LOCK = 1; bus.A_WE = 0; bus.A_AD = 8'd0;
      @(posedge CLK);
      @(negedge CLK);
      bus.B_REQ = 1; bus.B_WE = 0; bus.B_AD = 8'd1;
      ackSeq = '0; ackCount = 0; cyc = 0;
      while (ackCount < 5 && cyc < 80) begin
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
         if (bus.A_ACK || bus.B_ACK) begin
            ackSeq = {ackSeq[3:0], bus.B_ACK};
            ackCount++;
            if (ackCount == 5) begin
               bus.A_REQ = 0; bus.B_REQ = 0; bus.A_LOCK = 0;
            end
         end
      end
      checkOutput("lock_count", ackCount, 5);
      checkOutput("lock_order", ackSeq, 5'b00001);
`endif

      repeat (3) @(negedge CLK);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
